mmuart_rx_fifo: RTL and testbench

MMUART_RX_FIFO -- requirements
Module: mmuart_rx_fifo

---
 rtl/mmuart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_mmuart_rx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmuart_rx_fifo.sv
// 8N1 serial receiver for the MMUART_1_TXD stream feeding a first-word-fall-through byte FIFO.
// Sticky FRAME_ERR/OVERRUN flags are cleared by CLR_ERR.
`timescale 1ns/1ps
module mmuart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          RXD,
    input  logic                          RD_EN,
    input  logic                          CLR_ERR,
    output logic [7:0]                    RD_DATA,
    output logic                          EMPTY,
    output logic                          FULL,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          FRAME_ERR,
    output logic                          OVERRUN
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Two-flop synchronizer; the valid shifter marks when the sync output reflects real RXD
    logic       rxd_meta;
    logic       rxd_sync;
    logic [1:0] sync_vld_sr;
    logic       sync_vld;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rxd_meta    <= 1'b1;
            rxd_sync    <= 1'b1;
            sync_vld_sr <= 2'b00;
        end else begin
            rxd_meta    <= RXD;
            rxd_sync    <= rxd_meta;
            sync_vld_sr <= {sync_vld_sr[0], 1'b1};
        end
    end

    assign sync_vld = sync_vld_sr[1];

    rx_state_t       state;
    rx_state_t       state_nxt;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   bit_cnt_nxt;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_nxt;
    logic [7:0]      shift;
    logic [7:0]      shift_nxt;
    logic            armed;
    logic            armed_nxt;
    logic            wr_req;
    logic            wr_req_nxt;
    logic            fe_set;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            armed   <= 1'b0;
            wr_req  <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            armed   <= armed_nxt;
            wr_req  <= wr_req_nxt;
        end
    end

    // A start needs the line seen high while idle, so a held-low line never retriggers
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = CW'(bit_cnt + CW'(1));
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        armed_nxt   = armed;
        wr_req_nxt  = 1'b0;
        fe_set      = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                if (sync_vld && rxd_sync) begin
                    armed_nxt = 1'b1;
                end else if (armed && !rxd_sync) begin
                    armed_nxt = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_cnt == CW'(HALF - 1)) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rxd_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_nxt = '0;
                    shift_nxt   = {rxd_sync, shift[7:1]};
                    bit_idx_nxt = 3'(bit_idx + 3'd1);
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_cnt == CW'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = IDLE;
                    if (rxd_sync) begin
                        wr_req_nxt = 1'b1;
                    end else begin
                        fe_set = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FIFO: pointers wrap naturally at AW bits, flags derive from the occupancy counter
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          push;
    logic          ovr_set;

    assign EMPTY   = (count == '0);
    assign FULL    = (count == (AW+1)'(FIFO_DEPTH));
    assign COUNT   = count;
    assign pop     = RD_EN && !EMPTY;
    assign push    = wr_req && (!FULL || pop);
    assign ovr_set = wr_req && FULL && !pop;
    assign RD_DATA = EMPTY ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= AW'(wr_ptr + AW'(1));
            end
            if (pop) begin
                rd_ptr <= AW'(rd_ptr + AW'(1));
            end
            case ({push, pop})
                2'b10:   count <= (AW+1)'(count + (AW+1)'(1));
                2'b01:   count <= (AW+1)'(count - (AW+1)'(1));
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as CLR_ERR wins
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (fe_set) begin
                FRAME_ERR <= 1'b1;
            end else if (CLR_ERR) begin
                FRAME_ERR <= 1'b0;
            end
            if (ovr_set) begin
                OVERRUN <= 1'b1;
            end else if (CLR_ERR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmuart_rx_fifo.sv
// Scoreboard bench for mmuart_rx_fifo: serial frames are driven on RXD, expected bytes
// queue up as they are sent and are compared when popped from the FIFO.
`timescale 1ns/1ps
module tb_mmuart_rx_fifo;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];

    mmuart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .RXD       (rxd),
        .RD_EN     (rd_en),
        .CLR_ERR   (clr_err),
        .RD_DATA   (rd_data),
        .EMPTY     (empty),
        .FULL      (full),
        .COUNT     (count),
        .FRAME_ERR (frame_err),
        .OVERRUN   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame, LSB first; stop_bit=0 produces a framing error
    task automatic send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 rxd = frame[i];
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 rxd = 1'b1;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            check({tag, "_data"}, 32'(rd_data), 32'(exp_q.pop_front()));
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        tick(3);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // single byte
        send(8'hA5, 1'b1);
        expect_byte(8'hA5);
        tick(4);
        check("single_count", 32'(count), 32'd1);
        pop_check("single");
        check("single_empty_after", 32'(empty), 32'd1);
        check("single_count_after", 32'(count), 32'd0);

        // read while empty is ignored
        rd_en = 1'b1;
        tick(2);
        rd_en = 1'b0;
        check("rd_empty_count", 32'(count), 32'd0);
        check("rd_empty_ovr", 32'(overrun), 32'd0);

        // false start glitch
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        tick(40);
        check("glitch_empty", 32'(empty), 32'd1);
        check("glitch_fe", 32'(frame_err), 32'd0);

        // framing error
        send(8'h3C, 1'b0);
        tick(4);
        check("ferr_flag", 32'(frame_err), 32'd1);
        check("ferr_count", 32'(count), 32'd0);
        pulse_clr();
        check("ferr_cleared", 32'(frame_err), 32'd0);

        // overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1);
            expect_byte(8'(i));
        end
        tick(4);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overrun), 32'd1);
        for (int i = 0; i < 4; i++) pop_check("ovf_read");
        check("ovf_drained", 32'(empty), 32'd1);
        pulse_clr();
        check("ovf_cleared", 32'(overrun), 32'd0);

        // write and pop in the same cycle while full
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h21 + i), 1'b1);
            expect_byte(8'(8'h21 + i));
        end
        tick(2);
        check("simul_full_before", 32'(full), 32'd1);
        fork
            send(8'h25, 1'b1);
            begin
                repeat (156) @(posedge clk);
                #1;
                check("simul_head", 32'(rd_data), 32'(exp_q.pop_front()));
                rd_en = 1'b1;
                @(posedge clk);
                #1 rd_en = 1'b0;
            end
        join
        exp_q.push_back(8'h25);
        tick(4);
        check("simul_count", 32'(count), 32'd4);
        check("simul_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 4; i++) pop_check("simul_read");

        // pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                send(8'(8'h10 + r * 3 + k), 1'b1);
                expect_byte(8'(8'h10 + r * 3 + k));
            end
            tick(4);
            check("wrap_count", 32'(count), 32'd3);
            for (int k = 0; k < 3; k++) pop_check("wrap_read");
        end
        check("wrap_fe", 32'(frame_err), 32'd0);
        check("wrap_ovr", 32'(overrun), 32'd0);

        // reset mid-frame, with one byte already queued
        send(8'h77, 1'b1);
        tick(4);
        check("pre_rst_count", 32'(count), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 rxd = 1'b1;
            repeat (CPB - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rxd   = 1'b0;
        #2;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        tick(5);
        rst_n = 1'b1;
        tick(40);
        check("postrst_empty", 32'(empty), 32'd1);
        check("postrst_count", 32'(count), 32'd0);
        check("postrst_fe", 32'(frame_err), 32'd0);
        rxd = 1'b1;
        tick(20);
        send(8'h5A, 1'b1);
        expect_byte(8'h5A);
        tick(4);
        check("postrst_rx_count", 32'(count), 32'd1);
        pop_check("postrst_rx");
        check("final_empty", 32'(empty), 32'd1);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
